mux8_serial_scan_ctrl: RTL
==========================

Name: mux8_serial_scan_ctrl

Overview:
Sequencer that drives an external 8:1 data selector, a MUX8_1 instance with an active-low En, select S[2:0], data D[7:0], and outputs Y/Yn. The block turns that selector into an 8-bit parallel-to-serial converter. It loads a parallel byte and steps S through all eight inputs with En asserted low. It samples the selector's Y each cycle and emits a registered serial stream with valid/done flags. It also cross-checks Y against Yn and against the expected data bit, and flags any mismatch.

Parameters:
MSB_FIRST, 0, 0 = scan S 0→7 (LSB first); 1 = scan S 7→0.
GAP, 1, idle cycles (0..15) inserted after each word before Ready reasserts.

Ports:
CLK  in  1  clock, rising-edge.
RST  in  1  asynchronous, active-high reset.
Load  in  1  start request; accepted only when Ready=1.
Din  in  8  parallel word; captured on the accepted Load edge.
Clr_err  in  1  synchronous clear of Err.
Y_in  in  1  selector Y output (combinational from En/S/D).
Yn_in  in  1  selector Yn output.
Ready  out  1  high in IDLE only (combinational from state).
En  out  1  selector enable, active-low. 1 = selector disabled.
S  out  3  selector address.
D  out  8  selector data. Holds the captured word.
Sout  out  1  serial bit, registered.
Sout_valid  out  1  Sout qualifier.
Bit_idx  out  3  selector index that produced the current Sout.
Done  out  1  one-cycle pulse, coincident with the last Sout_valid.
Busy  out  1  high whenever state ≠ IDLE.
Err  out  1  sticky mismatch flag.

Behaviour:
- Reset (async, RST=1), all registers forced:
  - state=IDLE, En=1, S=0, D=0.
  - Sout=0, Sout_valid=0, Bit_idx=0, Done=0, Err=0.
  - GAP counter=0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Ready=1, Busy=0, En=1.
  - Load=1 at an edge: D←Din. Next state SHIFT. En←0. S←first index (0, or 7 if MSB_FIRST).
- SHIFT: exactly 8 cycles.
  - Each edge samples Y_in: Sout←Y_in, Sout_valid←1, Bit_idx←S.
  - S steps ±1 each edge.
  - On the 8th edge: En←1, Done←1. Next state is GAP, or IDLE if GAP=0.
  - S holds its last value after the scan.
- Timing, with the Load accepted at edge t:
  - SHIFT occupies cycles t+1..t+8.
  - Sout_valid=1 in cycles t+2..t+9.
  - Done=1 in cycle t+9 only. En=1 from cycle t+9.
  - Ready=1 again in cycle t+9+GAP.
- GAP:
  - Counts GAP cycles with En=1 and Sout_valid=0, then goes to IDLE.
- Sout_valid deasserts in every cycle that does not follow a SHIFT cycle.
- Load while Ready=0 is ignored; no queuing. Din changes during SHIFT have no effect because D is held.
- Checking, on every SHIFT-cycle edge:
  - Err←1 if Y_in == Yn_in.
  - Err←1 if Y_in ≠ D[S].
- Err handling:
  - Err is sticky. It clears only on RST, or on Clr_err=1 at an edge.
  - If Clr_err=1 and a new mismatch occur on the same edge, the set wins.
- RST mid-SHIFT: immediate return to the reset values. The partial word is discarded and no Done is issued.

Test Plan:
1. Reset check: RST=1 pulse → En=1, S=0, D=0, Sout_valid=0, Done=0, Err=0, Ready=1.
2. LSB-first scan: MSB_FIRST=0, GAP=1, Din=8'b0101_0101, one Load, behavioural MUX8_1 attached.
   - Sout over t+2..t+9 = 1,0,1,0,1,0,1,0 with Bit_idx 0..7.
   - Done high at t+9; Ready back at t+10; Err=0.
3. MSB-first, back-to-back: MSB_FIRST=1, GAP=0.
   - Din=8'b1111_1110, Load held high → Sout sequence 1,1,1,1,1,1,1,0 with Bit_idx 7..0.
   - Second word Din=8'h00 accepted at t+9 → eight 0s; no idle cycle between words.
4. Load while busy: pulse Load=1 with Din=8'hFF at t+4 → ignored, D stays 8'h55, output stream unchanged.
5. Fault injection: force Yn_in=Y_in at bit 3 → Err=1 from the next cycle and stays 1.
   - Clr_err pulse in IDLE → Err=0.
   - Force Y_in inverted on one bit → Err=1.
6. Reset mid-scan: RST asserted at t+5 → En=1 and Sout_valid=0 immediately, no Done pulse.
   - After release, Ready=1 and a new Load of 8'hA5 scans correctly: 1,0,1,0,0,1,0,1 LSB-first.

Source files
------------

// File: rtl/mux8_serial_scan_ctrl.sv
// Drives an external 8:1 selector as a parallel-to-serial converter and checks its Y/Yn outputs.
// Sout lags the selector address by one cycle; Load is only accepted in IDLE and is otherwise ignored.
module mux8_serial_scan_ctrl #(
    parameter bit MSB_FIRST = 1'b0,
    parameter int GAP       = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Load,
    input  logic [7:0] Din,
    input  logic       Clr_err,
    input  logic       Y_in,
    input  logic       Yn_in,
    output logic       Ready,
    output logic       En,
    output logic [2:0] S,
    output logic [7:0] D,
    output logic       Sout,
    output logic       Sout_valid,
    output logic [2:0] Bit_idx,
    output logic       Done,
    output logic       Busy,
    output logic       Err
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    localparam logic [2:0] FIRST_IDX = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] LAST_IDX  = MSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [3:0] GAP_END   = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t     state;
    logic [3:0] gap_cnt;
    logic       last_bit;
    logic       mismatch;
    logic [2:0] s_next;

    assign Ready    = (state == ST_IDLE);
    assign Busy     = (state != ST_IDLE);
    assign last_bit = (S == LAST_IDX);
    assign s_next   = MSB_FIRST ? (S - 3'd1) : (S + 3'd1);
    // A healthy selector gives complementary outputs that match the bit being addressed.
    assign mismatch = (Y_in == Yn_in) || (Y_in != D[S]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            gap_cnt    <= 4'd0;
            En         <= 1'b1;
            S          <= 3'd0;
            D          <= 8'd0;
            Sout       <= 1'b0;
            Sout_valid <= 1'b0;
            Bit_idx    <= 3'd0;
            Done       <= 1'b0;
            Err        <= 1'b0;
        end else begin
            Sout_valid <= 1'b0;
            Done       <= 1'b0;
            if (Clr_err) Err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Load) begin
                        D     <= Din;
                        S     <= FIRST_IDX;
                        En    <= 1'b0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    Sout       <= Y_in;
                    Sout_valid <= 1'b1;
                    Bit_idx    <= S;
                    // Placed after the clear so a fresh mismatch wins over Clr_err.
                    if (mismatch) Err <= 1'b1;
                    if (last_bit) begin
                        En      <= 1'b1;
                        Done    <= 1'b1;
                        gap_cnt <= 4'd0;
                        state   <= (GAP == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        S <= s_next;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_END) begin
                        gap_cnt <= 4'd0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
